// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous slow signal in clk_in cycles.
// Results update one cycle after a synchronized rising edge; there is no backpressure, valid is a single-cycle pulse.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PERIOD  = 2**CNT_W-1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             stable,
  output logic             timeout
);

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MAX_PERIOD - 1);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hcnt;
  logic                   r_have_prev;

  logic                   w_s;
  logic                   w_rise;
  logic [CNT_W-1:0]       w_period;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_s & ~r_s_d;
  // cnt never exceeds MAX_PERIOD-1, so cnt+1 always fits in CNT_W bits
  assign w_period = r_cnt + LP_ONE;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= w_s;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_have_prev <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      valid       <= 1'b0;
      stable      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The first edge only arms the meter; no result can exist yet.
          if (w_rise) begin
            r_cnt       <= '0;
            r_hcnt      <= LP_ONE;
            r_have_prev <= 1'b0;
            timeout     <= 1'b0;
            r_state     <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            period_out  <= w_period;
            high_out    <= r_hcnt;
            valid       <= 1'b1;
            stable      <= r_have_prev && (w_period == period_out) && (r_hcnt == high_out);
            r_have_prev <= 1'b1;
            r_cnt       <= '0;
            r_hcnt      <= LP_ONE;
          end else if (r_cnt == LP_CNT_LAST) begin
            // Edge on this same cycle would have won above, giving period MAX_PERIOD.
            timeout     <= 1'b1;
            stable      <= 1'b0;
            r_have_prev <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt  <= w_period;
            r_hcnt <= r_hcnt + CNT_W'(w_s);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter: an edge/gap-based reference model queues expected
// results with their cycle stamp; an independent monitor pops and compares them.
module tb_clk_period_meter;
  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int MAXP  = 16;
  localparam int NCYC  = 4096;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             stable;
  logic             timeout;

  always #5 clk_in = ~clk_in;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .MAX_PERIOD (MAXP)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (sig_in),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .stable    (stable),
    .timeout   (timeout)
  );

  typedef enum int {EV_RST, EV_VALID, EV_TO_SET, EV_TO_CLR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       p;
    int       h;
    bit       st;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  k = 0;

  bit  ws[NCYC];
  bit  rs[NCYC];
  bit  xs[NCYC];

  bit  m_armed = 0;
  bit  m_to = 0;
  bit  m_have_prev = 0;
  int  m_last = 0;
  int  m_p = 0;
  int  m_h = 0;

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t kind, input int cyc, input int p, input int h, input bit st);
    ev_t e;
    e = '{kind, cyc, p, h, st};
    q.push_back(e);
  endtask

  // Model: xs[n] is the synchronized view of the input after edge n (delayed, zeroed by reset).
  // Periods are distances between detected edges; high time is the count of high samples between them.
  task automatic model_edge(input int m);
    bit any_r;
    bit rise;
    int p;
    int h;
    bit st;
    any_r = 0;
    for (int j = m - SYNC + 1; j <= m; j++)
      if (j >= 0 && rs[j]) any_r = 1;
    xs[m] = (!any_r && (m - SYNC + 1) >= 0) ? ws[m - SYNC + 1] : 1'b0;
    rise = (m >= 2) && xs[m-1] && !xs[m-2];
    if (rs[m]) begin
      m_armed = 0; m_to = 0; m_have_prev = 0; m_p = 0; m_h = 0;
      push(EV_RST, m, 0, 0, 0);
    end else if (!m_armed) begin
      if (rise) begin
        m_armed = 1;
        m_last  = m;
        if (m_to) push(EV_TO_CLR, m, m_p, m_h, 0);
        m_to = 0;
      end
    end else if (rise) begin
      p = m - m_last;
      h = 0;
      for (int j = m_last - 1; j <= m - 2; j++) h += int'(xs[j]);
      st = m_have_prev && (p == m_p) && (h == m_h);
      push(EV_VALID, m, p, h, st);
      m_p = p; m_h = h; m_have_prev = 1; m_last = m;
    end else if (m - m_last == MAXP) begin
      push(EV_TO_SET, m, m_p, m_h, 0);
      m_armed = 0; m_to = 1; m_have_prev = 0;
    end
  endtask

  task automatic step(input bit w, input bit r);
    sig_in = w;
    rst    = r;
    ws[k]  = w;
    rs[k]  = r;
    model_edge(k);
    k++;
    @(negedge clk_in);
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < h; j++) step(1'b1, 1'b0);
      for (int j = 0; j < l; j++) step(1'b0, 1'b0);
    end
  endtask

  initial begin : monitor
    int  n;
    bit  prev_to;
    bit  got_v;
    bit  got_to;
    ev_t e;
    n = 0;
    prev_to = 0;
    forever begin
      @(posedge clk_in);
      #1;
      got_v  = 0;
      got_to = 0;
      while (q.size() > 0 && q[0].cyc <= n) begin
        e = q.pop_front();
        chk("event_cycle", n, n, e.cyc);
        case (e.kind)
          EV_RST: begin
            chk("rst_period", n, int'(period_out), 0);
            chk("rst_high", n, int'(high_out), 0);
            chk("rst_valid", n, int'(valid), 0);
            chk("rst_stable", n, int'(stable), 0);
            chk("rst_timeout", n, int'(timeout), 0);
            got_v = 1; got_to = 1;
          end
          EV_VALID: begin
            chk("valid_pulse", n, int'(valid), 1);
            chk("valid_period", n, int'(period_out), e.p);
            chk("valid_high", n, int'(high_out), e.h);
            chk("valid_stable", n, int'(stable), int'(e.st));
            chk("valid_timeout", n, int'(timeout), 0);
            got_v = 1;
          end
          EV_TO_SET: begin
            chk("to_set", n, int'(timeout), 1);
            chk("to_stable", n, int'(stable), 0);
            chk("to_hold_period", n, int'(period_out), e.p);
            chk("to_hold_high", n, int'(high_out), e.h);
            got_to = 1;
          end
          default: begin
            chk("to_clear", n, int'(timeout), 0);
            got_to = 1;
          end
        endcase
      end
      if (!got_v) chk("no_spurious_valid", n, int'(valid), 0);
      if (!got_to) chk("timeout_steady", n, int'(timeout), int'(prev_to));
      prev_to = timeout;
      n++;
    end
  end

  initial begin : stimulus
    int h;
    int l;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    wave(2, 2, 10);
    wave(3, 3, 6);
    wave(3, 7, 5);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    wave(2, 2, 6);
    wave(8, 8, 4);
    wave(9, 8, 3);
    wave(2, 2, 5);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    wave(2, 2, 5);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    wave(2, 2, 4);
    for (int i = 0; i < 40; i++) begin
      h = int'($urandom_range(1, 9));
      l = int'($urandom_range(1, 9));
      if ($urandom_range(0, 14) == 0) step(1'b1, 1'b1);
      wave(h, l, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 9) == 0)
        for (int j = 0; j < 20; j++) step(1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
    repeat (3) @(negedge clk_in);
    chk("queue_drained", k, q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous clock-like input in units of the system clock, the receiving-side counterpart to the clock divider. It synchronizes the input, detects rising edges, and counts `clk_in` cycles between consecutive edges. It reports each completed period with a one-cycle valid pulse, a stability flag and a timeout flag. Used in bring-up and self-check paths to confirm that divided clocks run at the expected ratio and duty cycle.

## Interface
- `CNT_W`, 16: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, 2: synchronizer flops on `sig_in`; minimum 2.
- `MAX_PERIOD`, 2**CNT_W-1: longest measurable period in `clk_in` cycles; must be ≤ 2**CNT_W-1.

Ports:
- `clk_in`, input, 1: system clock; all logic runs on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `sig_in`, input, 1: measured signal, asynchronous to `clk_in`.
- `period_out`, output, CNT_W: last completed period in `clk_in` cycles.
- `high_out`, output, CNT_W: number of high cycles in that period.
- `valid`, output, 1: one-cycle pulse when `period_out`/`high_out` update.
- `stable`, output, 1: last two completed periods were identical in both `period_out` and `high_out`.
- `timeout`, output, 1: sticky; no rising edge seen within `MAX_PERIOD` cycles.

## Operation
- Synchronizer: `sig_in` passes through SYNC_STAGES flops to give `s`. Register `s_d` holds `s` delayed one cycle.
- `rise` = `s & ~s_d`. Only rising edges delimit periods. Falling edges only affect the high count.
- States:
  - IDLE: entered at reset and after timeout. On `rise`: `cnt` ← 0, `hcnt` ← 1, clear `timeout`, go to MEASURE. No `valid` is produced in IDLE.
  - MEASURE, cycle without `rise`: `cnt` ← `cnt`+1, and `hcnt` ← `hcnt`+`s`.
  - MEASURE, cycle with `rise`:
    - `period_out` ← `cnt`+1 and `high_out` ← `hcnt`.
    - Pulse `valid`.
    - `stable` ← (`cnt`+1 == `period_out` old) && (`hcnt` == `high_out` old) && (an earlier valid exists since IDLE).
    - Restart with `cnt` ← 0 and `hcnt` ← 1.
- Timeout: in MEASURE, if `cnt` == MAX_PERIOD-1 and there is no `rise`:
  - Set `timeout`, clear `stable`, go to IDLE.
  - `period_out`/`high_out` hold their last values.
- Same-cycle conflict: `rise` on the cycle where `cnt` == MAX_PERIOD-1 wins. It yields a valid period of exactly MAX_PERIOD and no timeout.
- Counters never wrap: the timeout fires before `cnt` can exceed MAX_PERIOD-1, and `hcnt` ≤ `cnt`+1.
- A constant-high or constant-low `sig_in` produces no `rise` and ends in timeout. A glitch shorter than one `clk_in` period may be missed; this is allowed.

## Timing
- Reset values: `period_out`=0, `high_out`=0, `valid`=0, `stable`=0, `timeout`=0. State is IDLE, counters are 0, and `s` and `s_d` are 0.
- `rst` mid-measurement discards the partial period. The first `rise` after reset only arms the meter.
- Latency from a `sig_in` rising edge to `rise`: SYNC_STAGES+1 `clk_in` edges. `valid` and the updated outputs appear on the cycle after `rise`, for one cycle.
- The first `valid` after reset or timeout comes on the second detected rising edge.
- `timeout` is asserted on the cycle after the timeout condition and stays high until the next `rise` in IDLE. It clears on the cycle after that `rise`.
- `stable` changes only on a `valid` cycle or when timeout is entered.
- Minimum measurable period is 2 cycles. Period 1 is not detectable.

## Test plan
- Divide-by-4 square wave, 50 % duty, generated from `clk_in`, `rst` held 5 cycles: the first `valid` comes on the second edge with `period_out`=4 and `high_out`=2. `stable`=1 from the second `valid` on. `timeout` stays 0.
- `sig_in` high 3 / low 7 cycles, repeated: `period_out`=10, `high_out`=3, and `valid` spacing is exactly 10 cycles.
- Switch from divide-by-4 to divide-by-6 mid-run: one `valid` with the transitional period, where `stable` drops to 0. Then `period_out`=6, `high_out`=3, and `stable` returns to 1 two valids later.
- Stop `sig_in` low with MAX_PERIOD=16: `timeout`=1 exactly 16 cycles after the last `rise`, `stable`=0, and outputs hold 4/2. Restart the wave: `timeout` clears on the first edge, and `valid` resumes on the second.
- Square wave of exactly 16 cycles with MAX_PERIOD=16: `valid` with `period_out`=16 and no `timeout`.
- Assert `rst` for one cycle halfway through a period: all outputs are 0 the next cycle. No `valid` until two further edges, and the first value after reset is 4/2.
